ifu_fetch: RTL

- Instruction fetch stage directly upstream of the combinational instruction ROM.
- Owns the PC register and drives the ROM address. Captures the returned 32-bit instruction in the same cycle.
- Buffers {pc, inst} pairs in a 2-entry queue toward decode with a valid/ready handshake.
- Accepts redirects from execute (branch/jump) and a halt request.

---
 rtl/ifu_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational ROM and queues {pc, inst} pairs for decode.
// Optional performance counters are enabled with `define IFU_PERF_EN.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ILEN     = 32,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] rom_pc,
    input  logic [ILEN-1:0] rom_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic            out_misalign,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
`ifdef IFU_PERF_EN
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_flush_cnt,
`endif
    output logic            halted
);

    localparam int unsigned RegWidth  = XLEN;
    localparam int unsigned InstWidth = ILEN;
    localparam int unsigned CntWidth  = 2;

    typedef enum logic [1:0] {
        Boot      = 2'd0,
        Run       = 2'd1,
        WaitRedir = 2'd2,
        Halted    = 2'd3
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [RegWidth-1:0]   pc;
    logic [RegWidth-1:0]   pcQ   [2];
    logic [InstWidth-1:0]  instQ [2];
    logic                  misQ  [2];
    logic                  headIdx;
    logic                  tailIdx;
    logic [CntWidth-1:0]   count;
    logic                  deq;
    logic                  fetchMis;
    logic                  haltTake;
    logic                  redirTake;
    logic                  fetchEn;

    assign deq      = (count != '0) && out_ready;
    assign tailIdx  = headIdx ^ count[0];
    assign fetchMis = pc[1:0] != 2'b00;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= Boot;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        if (haltTake) begin
            nextState = Halted;
        end else if (redirTake) begin
            nextState = Run;
        end else begin
            case (state)
                Boot:    nextState = Run;
                Run:     if (fetchEn && fetchMis) nextState = WaitRedir;
                default: nextState = state;
            endcase
        end
    end

    // Control decode: halt beats redirect, and a full queue only accepts a fetch when it also drains
    always_comb begin
        haltTake  = 1'b0;
        redirTake = 1'b0;
        fetchEn   = 1'b0;
        haltTake  = halt_req && ((state == Run) || (state == WaitRedir));
        redirTake = redirect_valid && (state != Halted) && !haltTake;
        fetchEn   = (state == Run) && !halt_req && !redirect_valid
                    && ((count != CntWidth'(QDEPTH)) || deq);
    end

    // PC and queue occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RegWidth'(RESET_PC);
            count   <= '0;
            headIdx <= 1'b0;
        end else if (redirTake) begin
            pc      <= redirect_pc;
            count   <= '0;
            headIdx <= 1'b0;
        end else begin
            if (fetchEn) begin
                pc <= pc + RegWidth'(4);
            end
            if (deq) begin
                headIdx <= ~headIdx;
            end
            count <= count + CntWidth'(fetchEn) - CntWidth'(deq);
        end
    end

    // Queue payload; a full queue with a dequeue rewrites the slot being drained
    always_ff @(posedge clk) begin
        if (fetchEn) begin
            pcQ[tailIdx]   <= pc;
            instQ[tailIdx] <= rom_inst;
            misQ[tailIdx]  <= fetchMis;
        end
    end

`ifdef IFU_PERF_EN
    logic [63:0] perfFetch;
    logic [63:0] perfFlush;

    // Saturating event counters; a flush counts only if an entry is actually thrown away
    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetch <= '0;
            perfFlush <= '0;
        end else begin
            if (fetchEn && (perfFetch != '1)) begin
                perfFetch <= perfFetch + 64'd1;
            end
            if (redirTake && (count > CntWidth'(deq)) && (perfFlush != '1)) begin
                perfFlush <= perfFlush + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt = perfFetch;
    assign perf_flush_cnt = perfFlush;
`endif

    assign rom_pc       = pc;
    assign halted       = state == Halted;
    assign out_valid    = count != '0;
    assign out_pc       = out_valid ? pcQ[headIdx]   : '0;
    assign out_inst     = out_valid ? instQ[headIdx] : '0;
    assign out_misalign = out_valid ? misQ[headIdx]  : 1'b0;

endmodule
